// File: rtl/cycle_sequencer_if.sv
// Bus bundle between the cycle sequencer, the timing generator and the decoder.
// The master drives the timing/decoder inputs; the slave is the sequencer itself.
interface cycle_sequencer_if;
    logic [1:0] q;
    logic       rdy;
    logic       op_valid;
    logic [3:0] op_len;
    logic [7:0] op_wr_mask;
    logic       irq_req;
    logic       nmi_req;
    logic       i_flag;
    logic [3:0] t_state;
    logic [1:0] seq_state;
    logic       sync;
    logic       rw_n;
    logic       bus_en;
    logic [1:0] vec_sel;
    logic       int_ack;
    logic       cyc_adv;

    modport master (
        output q, rdy, op_valid, op_len, op_wr_mask, irq_req, nmi_req, i_flag,
        input  t_state, seq_state, sync, rw_n, bus_en, vec_sel, int_ack, cyc_adv
    );

    modport slave (
        input  q, rdy, op_valid, op_len, op_wr_mask, irq_req, nmi_req, i_flag,
        output t_state, seq_state, sync, rw_n, bus_en, vec_sel, int_ack, cyc_adv
    );
endinterface

// File: rtl/cycle_sequencer.sv
// 65C02 CPU-cycle scheduler: steps the reset, fetch, execute and interrupt-entry
// T-state machine once per CPU cycle and drives the per-cycle bus controls.
module cycle_sequencer #(
    parameter int MAX_T        = 8,
    parameter int RESET_CYCLES = 7,
    parameter int INT_CYCLES   = 7
) (
    input logic               fclk,
    input logic               reset,
    cycle_sequencer_if.slave  bus
);

    localparam logic [1:0] ST_RST   = 2'b00;
    localparam logic [1:0] ST_FETCH = 2'b01;
    localparam logic [1:0] ST_EXEC  = 2'b10;
    localparam logic [1:0] ST_INT   = 2'b11;

    localparam logic [3:0] T_RST_LAST = 4'(RESET_CYCLES - 1);
    localparam logic [3:0] T_INT_LAST = 4'(INT_CYCLES - 1);
    localparam logic [3:0] LEN_MAX    = 4'(MAX_T);

    // Instruction length clamped to [2, MAX_T]; a fetch plus at least one execute cycle.
    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        if (len < 4'd2) begin
            clamp_len = 4'd2;
        end else if (len > LEN_MAX) begin
            clamp_len = LEN_MAX;
        end else begin
            clamp_len = len;
        end
    endfunction

    logic [1:0] state_r, state_s;
    logic [3:0] t_r, t_s;
    logic [3:0] len_r, len_s;
    logic [7:0] mask_r, mask_s;
    logic       nmi_q_r, nmi_pend_r, nmi_pend_s, nmi_edge_s;
    logic       int_entry_s, take_nmi_s;
    logic       cyc_adv_s;
    logic       sync_r, sync_s;
    logic       rw_n_r, rw_n_s;
    logic       bus_en_r;
    logic [1:0] vec_sel_r, vec_sel_s;
    logic       int_ack_r;

    assign cyc_adv_s  = (bus.q == 2'd3) & bus.rdy;
    assign nmi_edge_s = bus.nmi_req & ~nmi_q_r;

    assign bus.cyc_adv   = cyc_adv_s;
    assign bus.t_state   = t_r;
    assign bus.seq_state = state_r;
    assign bus.sync      = sync_r;
    assign bus.rw_n      = rw_n_r;
    assign bus.bus_en    = bus_en_r;
    assign bus.vec_sel   = vec_sel_r;
    assign bus.int_ack   = int_ack_r;

    // State register: sequencer state, T-counter, latched instruction info, NMI edge tracking.
    always_ff @(posedge fclk) begin
        if (reset) begin
            state_r    <= ST_RST;
            t_r        <= 4'd0;
            len_r      <= 4'd2;
            mask_r     <= 8'h00;
            nmi_q_r    <= bus.nmi_req;
            nmi_pend_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            t_r        <= t_s;
            len_r      <= len_s;
            mask_r     <= mask_s;
            nmi_q_r    <= bus.nmi_req;
            nmi_pend_r <= nmi_pend_s;
        end
    end

    // Next-state logic: only a CPU-cycle advance moves the machine.
    always_comb begin
        state_s     = state_r;
        t_s         = t_r;
        len_s       = len_r;
        mask_s      = mask_r;
        int_entry_s = 1'b0;
        take_nmi_s  = 1'b0;
        if (cyc_adv_s) begin
            case (state_r)
                ST_RST: begin
                    if (t_r == T_RST_LAST) begin
                        state_s = ST_FETCH;
                        t_s     = 4'd0;
                    end else begin
                        t_s = t_r + 4'd1;
                    end
                end
                ST_FETCH: begin
                    if (nmi_pend_r | (bus.irq_req & ~bus.i_flag)) begin
                        state_s     = ST_INT;
                        t_s         = 4'd0;
                        int_entry_s = 1'b1;
                        take_nmi_s  = nmi_pend_r;
                    end else if (bus.op_valid) begin
                        state_s = ST_EXEC;
                        t_s     = 4'd1;
                        len_s   = clamp_len(bus.op_len);
                        mask_s  = bus.op_wr_mask;
                    end else begin
                        t_s = 4'd0;
                    end
                end
                ST_EXEC: begin
                    if (t_r == (len_r - 4'd1)) begin
                        state_s = ST_FETCH;
                        t_s     = 4'd0;
                    end else begin
                        t_s = t_r + 4'd1;
                    end
                end
                ST_INT: begin
                    if (t_r == T_INT_LAST) begin
                        state_s = ST_FETCH;
                        t_s     = 4'd0;
                    end else begin
                        t_s = t_r + 4'd1;
                    end
                end
                default: begin
                    state_s = ST_RST;
                    t_s     = 4'd0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
        // A fresh edge on the entry cycle keeps the NMI pending.
        nmi_pend_s = nmi_edge_s | (nmi_pend_r & ~take_nmi_s);
    end

    // Output decode from the upcoming state, so registered outputs line up with the state.
    always_comb begin
        sync_s = (state_s == ST_FETCH);
        case (state_s)
            ST_RST:   rw_n_s = 1'b1;
            ST_FETCH: rw_n_s = 1'b1;
            ST_EXEC:  rw_n_s = ~mask_s[t_s[2:0]];
            ST_INT:   rw_n_s = ~((t_s >= 4'd2) && (t_s <= 4'd4));
            default:  rw_n_s = 1'b1;
        endcase
        if (int_entry_s) begin
            vec_sel_s = take_nmi_s ? 2'b10 : 2'b11;
        end else if ((state_s == ST_FETCH) && (state_r != ST_FETCH)) begin
            vec_sel_s = 2'b00;
        end else begin
            vec_sel_s = vec_sel_r;
        end
    end

    // Output registers; bus_en stays low for the first fclk after reset releases.
    always_ff @(posedge fclk) begin
        if (reset) begin
            sync_r    <= 1'b0;
            rw_n_r    <= 1'b1;
            bus_en_r  <= 1'b0;
            vec_sel_r <= 2'b01;
            int_ack_r <= 1'b0;
        end else begin
            sync_r    <= sync_s;
            rw_n_r    <= rw_n_s;
            bus_en_r  <= 1'b1;
            vec_sel_r <= vec_sel_s;
            int_ack_r <= int_entry_s;
        end
    end

endmodule

// File: tb/tb_cycle_sequencer.sv
// Self-checking bench for cycle_sequencer: per-CPU-cycle vector table with a
// scoreboard queue, plus hand-written reset sequences.
module tb_cycle_sequencer;

    localparam int RS = 0;
    localparam int FE = 1;
    localparam int EX = 2;
    localparam int IN = 3;

    logic fclk = 1'b0;
    logic reset;

    cycle_sequencer_if bus();

    cycle_sequencer #(.MAX_T(8), .RESET_CYCLES(7), .INT_CYCLES(7)) dut (
        .fclk  (fclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 fclk = ~fclk;

    typedef struct {
        logic       rdy;
        logic       ov;
        logic [3:0] len;
        logic [7:0] mask;
        logic       irq;
        logic       nmi;
        logic       ifl;
        logic [1:0] seq;
        logic [3:0] t;
        logic       sync;
        logic       rw;
        logic [1:0] vec;
        logic       ack;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    vec_t prev;
    vec_t rstv;
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input int rdy, input int ov, input int len, input int mask,
                                input int irq, input int nmi, input int ifl, input int seq,
                                input int t, input int sync, input int rw, input int vec,
                                input int ack);
        vec_t v;
        v.rdy  = rdy[0];
        v.ov   = ov[0];
        v.len  = len[3:0];
        v.mask = mask[7:0];
        v.irq  = irq[0];
        v.nmi  = nmi[0];
        v.ifl  = ifl[0];
        v.seq  = seq[1:0];
        v.t    = t[3:0];
        v.sync = sync[0];
        v.rw   = rw[0];
        v.vec  = vec[1:0];
        v.ack  = ack[0];
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_out(input string tag, input vec_t e);
        chk({tag, "_seq_state"}, int'(bus.seq_state), int'(e.seq));
        chk({tag, "_t_state"},   int'(bus.t_state),   int'(e.t));
        chk({tag, "_sync"},      int'(bus.sync),      int'(e.sync));
        chk({tag, "_rw_n"},      int'(bus.rw_n),      int'(e.rw));
        chk({tag, "_vec_sel"},   int'(bus.vec_sel),   int'(e.vec));
    endtask

    task automatic drive(input vec_t v);
        bus.rdy        = v.rdy;
        bus.op_valid   = v.ov;
        bus.op_len     = v.len;
        bus.op_wr_mask = v.mask;
        bus.irq_req    = v.irq;
        bus.nmi_req    = v.nmi;
        bus.i_flag     = v.ifl;
    endtask

    // One CPU cycle: four fclk edges with q = 0..3, outputs must hold until the q==3 edge.
    task automatic run_cycle(input vec_t v);
        vec_t exp;
        drive(v);
        sb.push_back(v);
        for (int e = 0; e < 4; e++) begin
            #1;
            chk("cyc_adv", int'(bus.cyc_adv), (e == 3 && v.rdy) ? 1 : 0);
            @(posedge fclk);
            #1;
            if (e < 3) begin
                cmp_out("hold", prev);
                if (e == 0) chk("int_ack_width", int'(bus.int_ack), 0);
            end
            bus.q = bus.q + 2'd1;
        end
        exp = sb.pop_front();
        cmp_out("adv", exp);
        chk("int_ack", int'(bus.int_ack), int'(exp.ack));
        chk("bus_en", int'(bus.bus_en), 1);
        prev = exp;
    endtask

    task automatic rst_seq(input int nmi);
        for (int k = 1; k <= 7; k++) begin
            run_cycle(mk(1, 0, 0, 0, 0, nmi, 1, (k < 7) ? RS : FE, (k < 7) ? k : 0,
                         (k < 7) ? 0 : 1, 1, (k < 7) ? 1 : 0, 0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstv = mk(1, 0, 0, 0, 0, 0, 1, RS, 0, 0, 1, 1, 0);

        // rdy, ov, len, mask, irq, nmi, ifl -> seq, t, sync, rw_n, vec, int_ack
        tbl.push_back(mk(1, 1, 3,  8'h00, 0, 0, 1, EX, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  8'h00, 0, 0, 1, EX, 2, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  8'h00, 0, 0, 1, FE, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 1, 4,  8'h08, 0, 0, 1, EX, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  8'h00, 0, 0, 1, EX, 2, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  8'h00, 0, 0, 1, EX, 3, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0,  8'h00, 0, 0, 1, FE, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0,  8'h00, 0, 0, 1, EX, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  8'h00, 0, 0, 1, FE, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 1, 1,  8'h00, 0, 0, 1, EX, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  8'h00, 0, 0, 1, FE, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 1, 12, 8'h80, 0, 0, 1, EX, 1, 0, 1, 0, 0));
        for (int t = 2; t <= 6; t++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, EX, t, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  8'h00, 0, 0, 1, EX, 7, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0,  8'h00, 0, 0, 1, FE, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  8'h00, 0, 0, 1, FE, 0, 1, 1, 0, 0));
        // RDY stall at EXEC t=1 for two CPU cycles
        tbl.push_back(mk(1, 1, 3,  8'h00, 0, 0, 1, EX, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0,  8'h00, 0, 0, 1, EX, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0,  8'h00, 0, 0, 1, EX, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  8'h00, 0, 0, 1, EX, 2, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  8'h00, 0, 0, 1, FE, 0, 1, 1, 0, 0));
        // IRQ masked by i_flag, then taken
        tbl.push_back(mk(1, 1, 2,  8'h00, 1, 0, 1, EX, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  8'h00, 1, 0, 1, FE, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 1, 2,  8'h00, 1, 0, 0, IN, 0, 0, 1, 3, 1));
        for (int t = 1; t <= 6; t++)
            tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, IN, t, 0, (t >= 2 && t <= 4) ? 0 : 1, 3, 0));
        tbl.push_back(mk(1, 0, 0,  8'h00, 0, 0, 0, FE, 0, 1, 1, 0, 0));
        // NMI level held across two fetches: one entry only
        tbl.push_back(mk(1, 1, 2,  8'h00, 0, 1, 1, IN, 0, 0, 1, 2, 1));
        for (int t = 1; t <= 6; t++)
            tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, IN, t, 0, (t >= 2 && t <= 4) ? 0 : 1, 2, 0));
        tbl.push_back(mk(1, 0, 0,  8'h00, 0, 1, 1, FE, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 1, 2,  8'h00, 0, 1, 1, EX, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  8'h00, 0, 1, 1, FE, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  8'h00, 0, 0, 1, FE, 0, 1, 1, 0, 0));
        // Into EXEC t=2 with an NMI pending, ready for a mid-instruction reset
        tbl.push_back(mk(1, 1, 4,  8'h00, 0, 0, 1, EX, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  8'h00, 0, 1, 1, EX, 2, 0, 1, 0, 0));

        reset = 1'b1;
        bus.q = 2'd0;
        drive(rstv);
        repeat (2) @(posedge fclk);
        #1;
        cmp_out("reset", rstv);
        chk("reset_bus_en", int'(bus.bus_en), 0);
        chk("reset_int_ack", int'(bus.int_ack), 0);
        reset = 1'b0;
        prev  = rstv;
        chk("release_bus_en", int'(bus.bus_en), 0);
        rst_seq(0);

        foreach (tbl[i]) run_cycle(tbl[i]);

        // Reset mid-instruction with NMI pending; NMI level stays high afterwards
        reset = 1'b1;
        @(posedge fclk);
        #1;
        cmp_out("mid_reset", rstv);
        chk("mid_reset_bus_en", int'(bus.bus_en), 0);
        chk("mid_reset_int_ack", int'(bus.int_ack), 0);
        reset = 1'b0;
        bus.q = 2'd0;
        prev  = rstv;
        chk("mid_release_bus_en", int'(bus.bus_en), 0);
        rst_seq(1);
        run_cycle(mk(1, 1, 2, 8'h00, 0, 1, 1, EX, 1, 0, 1, 0, 0));
        run_cycle(mk(1, 0, 0, 8'h00, 0, 1, 1, FE, 0, 1, 1, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
